// File: rtl/run_sequencer.sv
// Game-level sequencer for the T-Rex runner: IDLE/RUN/DEAD control, frame tick,
// score/speed keeping, LFSR-randomised obstacle spawning and jump pulse generation.
module run_sequencer #(
  parameter int unsigned FRAME_DIV  = 416667,
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned SPEED_STEP = 100,
  parameter int unsigned MAX_LEVEL  = 7,
  parameter int unsigned GAP_MIN    = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        jump_btn,
  input  logic        collided,
  output logic [2:0]  state,
  output logic        run,
  output logic        dead,
  output logic        frame_tick,
  output logic [13:0] score,
  output logic [2:0]  speed,
  output logic        spawn,
  output logic [1:0]  spawn_type,
  output logic        jump
);

  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned SW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int unsigned GW = $clog2(GAP_MIN + 32) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_RUN  = 3'b001,
    S_DEAD = 3'b100
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_fcnt;
  logic [SW-1:0] r_step;
  logic [GW-1:0] r_gap;
  logic [15:0]   r_lfsr;
  logic          r_jb_q;

  logic          w_jb_rise;
  logic          w_enter_run;
  logic          w_tick_now;
  logic          w_spawn_now;
  logic          w_lfsr_fb;
  logic [GW-1:0] w_spd2;
  logic [GW-1:0] w_reload;

  assign w_jb_rise   = jump_btn & ~r_jb_q;
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_enter_run = (w_next == S_RUN) && (r_state != S_RUN);
  assign w_tick_now  = (r_state == S_RUN) && start && (r_fcnt == FW'(FRAME_DIV - 1));
  assign w_spawn_now = w_tick_now && (r_gap == GW'(1));
  // Entry reload sees the freshly cleared speed; spawn reload sees the pre-tick speed.
  assign w_spd2      = w_enter_run ? '0 : GW'({r_speed_dbl_src(speed), 1'b0});
  assign w_reload    = GW'(GAP_MIN) + GW'(r_lfsr[4:0]) - w_spd2;

  function automatic logic [2:0] r_speed_dbl_src(input logic [2:0] v);
    return v;
  endfunction

  assign state = r_state;

  always_comb begin
    w_next = r_state;
    if (!start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_RUN;
        S_RUN:   if (collided) w_next = S_DEAD;
        S_DEAD:  if (w_jb_rise && !collided) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      dead       <= 1'b0;
      frame_tick <= 1'b0;
      score      <= '0;
      speed      <= '0;
      spawn      <= 1'b0;
      spawn_type <= '0;
      jump       <= 1'b0;
      r_fcnt     <= '0;
      r_step     <= '0;
      r_gap      <= '0;
      r_lfsr     <= 16'hACE1;
      r_jb_q     <= 1'b0;
    end else begin
      run        <= (w_next == S_RUN);
      dead       <= (w_next == S_DEAD);
      frame_tick <= w_tick_now;
      spawn      <= w_spawn_now;
      spawn_type <= w_spawn_now ? r_lfsr[6:5] : 2'b00;
      jump       <= w_jb_rise && (r_state == S_RUN) && !collided;
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      r_jb_q     <= jump_btn;

      if (w_enter_run) begin
        r_fcnt <= '0;
        r_step <= '0;
        score  <= '0;
        speed  <= '0;
        r_gap  <= w_reload;
      end else if ((r_state == S_RUN) && start) begin
        r_fcnt <= (w_tick_now || (w_next != S_RUN)) ? '0 : r_fcnt + 1'b1;
        if (w_tick_now) begin
          if (score < 14'(SCORE_MAX)) begin
            score <= score + 1'b1;
          end
          if (r_step == SW'(SPEED_STEP - 1)) begin
            r_step <= '0;
            if (speed < 3'(MAX_LEVEL)) begin
              speed <= speed + 1'b1;
            end
          end else begin
            r_step <= r_step + 1'b1;
          end
          r_gap <= w_spawn_now ? w_reload : r_gap - 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

endmodule
